// File: rtl/unidade_de_controle_multiciclo.sv
// unidade_de_controle_multiciclo: multi-cycle FSM control unit of the Zeus core
// Ports: clk, rst_n (async active-low); Op_Code is captured in FETCH; alu_zero/alu_neg resolve
// branches in EXEC; entrada_valida releases the WAIT_IN stall.
// Outputs: datapath controls (RegDst, RegWrite, AluSrc, ALUOp, MemWrite, MemRead, MemToReg,
// PCSrc, pc_write, ir_write), I/O handshake (print, ler_da_entrada, confirma_entrada),
// Sinal_da_Conta ALU operation, sticky illegal_op, estado debug state.
// Optional: define ZEUS_WAIT_TIMEOUT_EN to bound WAIT_IN by TIMEOUT_CYCLES and add timeout_evt.
module unidade_de_controle_multiciclo #(
   parameter int OPCODE_W       = 6,
   parameter int ALU_CTRL_W     = 6,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [OPCODE_W-1:0]   Op_Code,
   input  logic                  alu_zero,
   input  logic                  alu_neg,
   input  logic                  entrada_valida,
   output logic                  RegDst,
   output logic                  RegWrite,
   output logic                  AluSrc,
   output logic                  ALUOp,
   output logic                  MemWrite,
   output logic                  MemRead,
   output logic                  MemToReg,
   output logic                  PCSrc,
   output logic                  pc_write,
   output logic                  ir_write,
   output logic                  print,
   output logic                  ler_da_entrada,
   output logic                  confirma_entrada,
   output logic [ALU_CTRL_W-1:0] Sinal_da_Conta,
   output logic                  illegal_op,
`ifdef ZEUS_WAIT_TIMEOUT_EN
   output logic                  timeout_evt,
`endif
   output logic [2:0]            estado
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, WAIT_IN = 3'd5} state_t;
   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_BLEZ = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_BGTZ = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(11);
   localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(12);
   localparam logic [OPCODE_W-1:0] OP_WAIT = OPCODE_W'(13);
   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q;
   logic                illegal_q, is_branch, is_exec, taken, redirect, tmo;
   assign is_branch = op_q inside {OP_BEQ, OP_BLEZ, OP_BNE, OP_BGTZ};
   assign is_exec   = is_branch || (op_q inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_J, OP_OUT});
   assign taken     = (op_q == OP_BEQ  &&  alu_zero) ||
                      (op_q == OP_BNE  && !alu_zero) ||
                      (op_q == OP_BLEZ && (alu_zero || alu_neg)) ||
                      (op_q == OP_BGTZ && !alu_zero && !alu_neg);
   // PC redirect is the only flag-dependent (combinational) output path
   assign redirect  = state_q == EXEC && (op_q == OP_J || (is_branch && taken));
`ifdef ZEUS_WAIT_TIMEOUT_EN
   localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt_q;
   // cnt_q is 0 on the first WAIT_IN cycle, so cycle N of the stall sees N-1
   assign tmo         = state_q == WAIT_IN && !entrada_valida && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
   assign timeout_evt = tmo;
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:   state_d = DECODE;
         DECODE:  state_d = is_exec ? EXEC : op_q == OP_IN ? WB : op_q == OP_WAIT ? WAIT_IN : FETCH;
         EXEC:    state_d = op_q inside {OP_R, OP_ADDI} ? WB : op_q inside {OP_LW, OP_SW} ? MEM : FETCH;
         MEM:     state_d = op_q == OP_LW ? WB : FETCH;
         WAIT_IN: state_d = (entrada_valida || tmo) ? FETCH : WAIT_IN;
         default: state_d = FETCH;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         op_q      <= '0;
         illegal_q <= 1'b0;
`ifdef ZEUS_WAIT_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == FETCH) op_q <= Op_Code;
         // DECODE falls straight back to FETCH only for undefined opcodes
         if (state_q == DECODE && state_d == FETCH) illegal_q <= 1'b1;
`ifdef ZEUS_WAIT_TIMEOUT_EN
         cnt_q <= (state_q == WAIT_IN && state_d == WAIT_IN) ? cnt_q + 1'b1 : '0;
`endif
      end
   end
   assign ir_write         = state_q == FETCH;
   assign pc_write         = ir_write || redirect;
   assign PCSrc            = redirect;
   assign ALUOp            = state_q == EXEC && op_q == OP_R;
   assign AluSrc           = state_q == EXEC && (op_q inside {OP_ADDI, OP_LW, OP_SW});
   assign Sinal_da_Conta   = (state_q == EXEC && is_branch) ? ALU_CTRL_W'(4) : '0;
   assign print            = state_q == EXEC && op_q == OP_OUT;
   assign MemWrite         = state_q == MEM && op_q == OP_SW;
   assign MemRead          = (state_q == MEM || state_q == WB) && op_q == OP_LW;
   assign RegWrite         = state_q == WB;
   assign RegDst           = RegWrite && op_q == OP_R;
   assign MemToReg         = RegWrite && op_q == OP_LW;
   assign confirma_entrada = RegWrite && op_q == OP_IN;
   assign ler_da_entrada   = state_q == WAIT_IN;
   assign illegal_op       = illegal_q;
   assign estado           = state_q;
endmodule

// File: tb/tb_unidade_de_controle_multiciclo.sv
// tb_unidade_de_controle_multiciclo: scoreboard bench for the multi-cycle control unit
module tb_unidade_de_controle_multiciclo;
   localparam int TMO = 8;
   typedef struct packed {
      logic [2:0] est;
      logic reg_dst, reg_write, alu_src, alu_op, mem_write, mem_read, mem_to_reg;
      logic pc_src, pc_write, ir_write, print, ler, conf;
      logic [5:0] conta;
      logic ill, tmo;
   } vec_t;
   logic clk = 0, rst_n = 0, alu_zero = 0, alu_neg = 0, entrada_valida = 0;
   logic [5:0] Op_Code = 0;
   logic RegDst, RegWrite, AluSrc, ALUOp, MemWrite, MemRead, MemToReg, PCSrc, pc_write, ir_write;
   logic print, ler_da_entrada, confirma_entrada, illegal_op, timeout_evt;
   logic [5:0] Sinal_da_Conta;
   logic [2:0] estado;
   vec_t act, e_mon;
   vec_t q[$];
   int checks = 0, failures = 0;
   logic ill_m = 0;
   always #5 clk = ~clk;
   unidade_de_controle_multiciclo #(.OPCODE_W(6), .ALU_CTRL_W(6), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .Op_Code(Op_Code), .alu_zero(alu_zero), .alu_neg(alu_neg),
      .entrada_valida(entrada_valida), .RegDst(RegDst), .RegWrite(RegWrite), .AluSrc(AluSrc),
      .ALUOp(ALUOp), .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg), .PCSrc(PCSrc),
      .pc_write(pc_write), .ir_write(ir_write), .print(print), .ler_da_entrada(ler_da_entrada),
      .confirma_entrada(confirma_entrada), .Sinal_da_Conta(Sinal_da_Conta), .illegal_op(illegal_op),
`ifdef ZEUS_WAIT_TIMEOUT_EN
      .timeout_evt(timeout_evt),
`endif
      .estado(estado));
`ifndef ZEUS_WAIT_TIMEOUT_EN
   assign timeout_evt = 1'b0;
`endif
   assign act = {estado, RegDst, RegWrite, AluSrc, ALUOp, MemWrite, MemRead, MemToReg, PCSrc, pc_write,
                 ir_write, print, ler_da_entrada, confirma_entrada, Sinal_da_Conta, illegal_op, timeout_evt};
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e_mon = q.pop_front();
         checks++;
         if (act !== e_mon) begin
            failures++;
            $display("FAIL outputs t=%0t estado got=%0d want=%0d vector got=%h want=%h",
                     $time, act.est, e_mon.est, act, e_mon);
         end
      end
   end
   function automatic logic rb();
      return 1'($urandom);
   endfunction
   function automatic vec_t st(input logic [2:0] s);
      vec_t v = '0;
      v.est = s;
      return v;
   endfunction
   function automatic vec_t fetch_v();
      vec_t v = st(0);
      v.pc_write = 1;
      v.ir_write = 1;
      return v;
   endfunction
   task automatic step(input vec_t e, input logic ev, input logic z, input logic n, input logic [5:0] op);
      Op_Code = op;
      entrada_valida = ev;
      alu_zero = z;
      alu_neg = n;
      e.ill = ill_m;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic run(input logic [5:0] op, input logic z, input logic n, input int stall, input bit abort);
      vec_t e;
      logic taken;
      step(fetch_v(), rb(), rb(), rb(), op);
      step(st(1), rb(), rb(), rb(), 6'($urandom));
      if (op == 11) begin
         e = st(4); e.reg_write = 1; e.conf = 1;
         step(e, rb(), rb(), rb(), 6'($urandom));
         return;
      end
      if (op == 13) begin
         for (int k = 1; k <= stall + 1; k++) begin
            e = st(5); e.ler = 1;
`ifdef ZEUS_WAIT_TIMEOUT_EN
            if (k == TMO && k <= stall) begin
               e.tmo = 1;
               step(e, 0, rb(), rb(), 6'($urandom));
               checks++;
               if (estado !== 3'd0) begin
                  failures++;
                  $display("FAIL expired wait t=%0t estado got=%0d want=0", $time, estado);
               end
               return;
            end
`endif
            step(e, k > stall, rb(), rb(), 6'($urandom));
         end
         checks++;
         if (estado !== 3'd0) begin
            failures++;
            $display("FAIL wait exit t=%0t estado got=%0d want=0", $time, estado);
         end
         return;
      end
      if (!(op inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 12})) begin
         ill_m = 1;
         return;
      end
      case (op)
         2: taken = z;
         3: taken = z | n;
         4: taken = !z;
         5: taken = !z && !n;
         default: taken = 0;
      endcase
      e = st(2);
      case (op)
         0: e.alu_op = 1;
         1, 6, 7: e.alu_src = 1;
         2, 3, 4, 5: begin e.conta = 6'd4; e.pc_src = taken; e.pc_write = taken; end
         8: begin e.pc_src = 1; e.pc_write = 1; end
         12: e.print = 1;
         default: ;
      endcase
      step(e, rb(), z, n, 6'($urandom));
      if (!(op inside {0, 1, 6, 7})) return;
      if (op inside {6, 7}) begin
         e = st(3);
         if (op == 6) e.mem_read = 1; else e.mem_write = 1;
         if (abort && op == 7) begin
            rst_n = 0;
            ill_m = 0;
            step(fetch_v(), rb(), rb(), rb(), 6'($urandom));
            rst_n = 1;
            return;
         end
         step(e, rb(), rb(), rb(), 6'($urandom));
         if (op == 7) return;
      end
      e = st(4); e.reg_write = 1;
      if (op == 0) e.reg_dst = 1;
      if (op == 6) begin e.mem_to_reg = 1; e.mem_read = 1; end
      step(e, rb(), rb(), rb(), 6'($urandom));
   endtask
   initial begin
      int sel;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (estado !== 3'd0 || illegal_op !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 ||
          PCSrc !== 1'b0 || confirma_entrada !== 1'b0) begin
         failures++;
         $display("FAIL reset state t=%0t estado=%0d illegal_op=%b", $time, estado, illegal_op);
      end
      step(fetch_v(), 0, 0, 0, 0);
      rst_n = 1;
      run(0, 0, 0, 0, 0);
      run(6, 0, 0, 0, 0);
      run(7, 0, 0, 0, 0);
      run(2, 1, 0, 0, 0);
      run(4, 1, 0, 0, 0);
      run(5, 0, 0, 0, 0);
      run(3, 0, 1, 0, 0);
      run(13, 0, 0, 10, 0);
      run(11, 0, 0, 0, 0);
      run(13, 0, 0, 0, 0);
      run(63, 0, 0, 0, 0);
      run(0, 0, 0, 0, 0);
      run(8, 0, 0, 0, 0);
      run(12, 0, 0, 0, 0);
      run(7, 0, 0, 0, 1);
      run(1, 0, 0, 0, 0);
      repeat (300) begin
         sel = $urandom_range(0, 16);
         run(sel == 16 ? 6'd63 : 6'(sel), rb(), rb(), $urandom_range(0, 12), $urandom_range(0, 19) == 0);
      end
      #20;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
